// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the shared datapath.
// master = controller side, slave = datapath/memory side.
interface multicycle_controller_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7_5;
   logic       zero;
   logic       mem_ready;
   logic       mem_req;
   logic       pc_write;
   logic       adr_src;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] imm_src;
   logic [2:0] alu_control;
   logic       illegal_op;

   modport master (
      input  op, funct3, funct7_5, zero, mem_ready,
      output mem_req, pc_write, adr_src, mem_write, ir_write,
      output reg_write, result_src, alu_src_a, alu_src_b,
      output imm_src, alu_control, illegal_op
   );

   modport slave (
      output op, funct3, funct7_5, zero, mem_ready,
      input  mem_req, pc_write, adr_src, mem_write, ir_write,
      input  reg_write, result_src, alu_src_a, alu_src_b,
      input  imm_src, alu_control, illegal_op
   );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RISC-V core,
// with ALU and immediate-format decoders.
module multicycle_controller (
   input  logic clk,
   input  logic rst_n,
   multicycle_controller_if.master bus
);
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] alu_op;
   logic       branch, pc_update;
   logic       mem_req_c, mem_write_c, ir_write_c;
   logic       reg_write_c, illegal_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      alu_op         = 2'b00;
      branch         = 1'b0;
      pc_update      = 1'b0;
      mem_req_c      = 1'b0;
      mem_write_c    = 1'b0;
      ir_write_c     = 1'b0;
      reg_write_c    = 1'b0;
      illegal_c      = 1'b0;
      bus.adr_src    = 1'b0;
      bus.result_src = 2'b00;
      bus.alu_src_a  = 2'b00;
      bus.alu_src_b  = 2'b00;
      case (state_q)
         S_FETCH: begin
            mem_req_c      = 1'b1;
            bus.alu_src_b  = 2'b10;
            bus.result_src = 2'b10;
            ir_write_c     = bus.mem_ready;
            pc_update      = bus.mem_ready;
            if (bus.mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            bus.alu_src_a = 2'b01;
            bus.alu_src_b = 2'b01;
            case (bus.op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_BEQ:            state_d = S_BEQ;
               OP_JAL:            state_d = S_JAL;
               default: begin
                  state_d   = S_FETCH;
                  illegal_c = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            bus.alu_src_a = 2'b10;
            bus.alu_src_b = 2'b01;
            state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            mem_req_c   = 1'b1;
            bus.adr_src = 1'b1;
            if (bus.mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            bus.result_src = 2'b01;
            reg_write_c    = 1'b1;
            state_d        = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req_c   = 1'b1;
            mem_write_c = 1'b1;
            bus.adr_src = 1'b1;
            if (bus.mem_ready) state_d = S_FETCH;
         end
         S_EXECR: begin
            bus.alu_src_a = 2'b10;
            alu_op        = 2'b10;
            state_d       = S_ALUWB;
         end
         S_EXECI: begin
            bus.alu_src_a = 2'b10;
            bus.alu_src_b = 2'b01;
            alu_op        = 2'b10;
            state_d       = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_c = 1'b1;
            state_d     = S_FETCH;
         end
         S_BEQ: begin
            bus.alu_src_a = 2'b10;
            alu_op        = 2'b01;
            branch        = 1'b1;
            state_d       = S_FETCH;
         end
         S_JAL: begin
            bus.alu_src_a = 2'b01;
            bus.alu_src_b = 2'b10;
            pc_update     = 1'b1;
            state_d       = S_ALUWB;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Enables are gated by rst_n so an async reset drops them at once.
   assign bus.mem_req    = rst_n & mem_req_c;
   assign bus.mem_write  = rst_n & mem_write_c;
   assign bus.ir_write   = rst_n & ir_write_c;
   assign bus.reg_write  = rst_n & reg_write_c;
   assign bus.illegal_op = rst_n & illegal_c;
   assign bus.pc_write   = rst_n & (pc_update | (branch & bus.zero));

   always_comb begin
      bus.alu_control = 3'b000;
      case (alu_op)
         2'b01: bus.alu_control = 3'b001;
         2'b10: begin
            case (bus.funct3)
               3'b000:  bus.alu_control = (bus.op[5] & bus.funct7_5)
                                          ? 3'b001 : 3'b000;
               3'b010:  bus.alu_control = 3'b101;
               3'b110:  bus.alu_control = 3'b011;
               3'b111:  bus.alu_control = 3'b010;
               default: bus.alu_control = 3'b000;
            endcase
         end
         default: bus.alu_control = 3'b000;
      endcase
   end

   always_comb begin
      case (bus.op)
         OP_STORE: bus.imm_src = 2'b01;
         OP_BEQ:   bus.imm_src = 2'b10;
         OP_JAL:   bus.imm_src = 2'b11;
         default:  bus.imm_src = 2'b00;
      endcase
   end
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed cycle-by-cycle bench for multicycle_controller;
// expected output words go through a scoreboard queue.
module tb_multicycle_controller;
   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp  = 0;
   int   n_fail = 0;

   string       tag_q[$];
   logic [17:0] exp_q[$];

   multicycle_controller_if bus();

   multicycle_controller dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // {mem_req,pc_write,adr_src,mem_write,ir_write,reg_write,
   //  result_src,alu_src_a,alu_src_b,imm_src,alu_control,illegal_op}
   function automatic logic [17:0] e(
      input logic mr, pw, ad, mw, iw, rw,
      input logic [1:0] rs, sa, sb, im,
      input logic [2:0] ac, input logic il);
      return {mr, pw, ad, mw, iw, rw, rs, sa, sb, im, ac, il};
   endfunction

   function automatic logic [17:0] obs();
      return {bus.mem_req, bus.pc_write, bus.adr_src, bus.mem_write,
              bus.ir_write, bus.reg_write, bus.result_src,
              bus.alu_src_a, bus.alu_src_b, bus.imm_src,
              bus.alu_control, bus.illegal_op};
   endfunction

   task automatic pop_cmp();
      string       t;
      logic [17:0] x, o;
      t = tag_q.pop_front();
      x = exp_q.pop_front();
      o = obs();
      n_cmp++;
      assert (o === x) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", t, o, x);
      end
   endtask

   // One clock: push expectation, compare at negedge, resume after posedge.
   task automatic cyc(input string t, input logic [17:0] x);
      tag_q.push_back(t);
      exp_q.push_back(x);
      @(negedge clk);
      pop_cmp();
      @(posedge clk);
      #1;
   endtask

   task automatic now(input string t, input logic [17:0] x);
      tag_q.push_back(t);
      exp_q.push_back(x);
      pop_cmp();
   endtask

   function automatic logic [17:0] s_fetch(input logic rdy,
                                           input logic [1:0] im);
      return e(1, rdy, 0, 0, rdy, 0, 2'b10, 2'b00, 2'b10, im, 3'b000, 0);
   endfunction

   function automatic logic [17:0] s_dec(input logic [1:0] im,
                                         input logic il);
      return e(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, 3'b000, il);
   endfunction

   function automatic logic [17:0] s_aluwb(input logic [1:0] im);
      return e(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 3'b000, 0);
   endfunction

   function automatic logic [17:0] s_memadr(input logic [1:0] im);
      return e(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 3'b000, 0);
   endfunction

   function automatic logic [17:0] s_memwr(input logic [1:0] im);
      return e(1, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0);
   endfunction

   task automatic set_ins(input logic [6:0] o, input logic [2:0] f3,
                          input logic f7);
      bus.op       = o;
      bus.funct3   = f3;
      bus.funct7_5 = f7;
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.mem_ready = 1'b1;
      bus.zero      = 1'b0;
      set_ins(7'b0110011, 3'b000, 1'b0);

      repeat (2) @(posedge clk);
      #1;
      cyc("reset_hold", s_fetch(0, 2'b00) & ~18'h20000);
      rst_n = 1'b1;
      cyc("reset_release", s_fetch(1, 2'b00));

      // add
      cyc("add_decode", s_dec(2'b00, 0));
      cyc("add_execr",
          e(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, 0));
      cyc("add_aluwb", s_aluwb(2'b00));

      // sub
      set_ins(7'b0110011, 3'b000, 1'b1);
      cyc("sub_fetch", s_fetch(1, 2'b00));
      cyc("sub_decode", s_dec(2'b00, 0));
      cyc("sub_execr",
          e(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 0));
      cyc("sub_aluwb", s_aluwb(2'b00));

      // I-type ori: funct3 110 -> or
      set_ins(7'b0010011, 3'b110, 1'b1);
      cyc("ori_fetch", s_fetch(1, 2'b00));
      cyc("ori_decode", s_dec(2'b00, 0));
      cyc("ori_execi",
          e(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b011, 0));
      cyc("ori_aluwb", s_aluwb(2'b00));

      // R-type slt
      set_ins(7'b0110011, 3'b010, 1'b0);
      cyc("slt_fetch", s_fetch(1, 2'b00));
      cyc("slt_decode", s_dec(2'b00, 0));
      cyc("slt_execr",
          e(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b101, 0));
      cyc("slt_aluwb", s_aluwb(2'b00));

      // lw with two wait cycles in MEMREAD
      set_ins(7'b0000011, 3'b010, 1'b0);
      cyc("lw_fetch", s_fetch(1, 2'b00));
      cyc("lw_decode", s_dec(2'b00, 0));
      cyc("lw_memadr", s_memadr(2'b00));
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 2; i++)
         cyc("lw_memread_wait",
             e(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      bus.mem_ready = 1'b1;
      cyc("lw_memread_rdy",
          e(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      cyc("lw_memwb",
          e(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0));

      // sw with one fetch stall and one MEMWRITE stall
      set_ins(7'b0100011, 3'b010, 1'b0);
      bus.mem_ready = 1'b0;
      cyc("sw_fetch_wait", s_fetch(0, 2'b01));
      bus.mem_ready = 1'b1;
      cyc("sw_fetch", s_fetch(1, 2'b01));
      cyc("sw_decode", s_dec(2'b01, 0));
      cyc("sw_memadr", s_memadr(2'b01));
      bus.mem_ready = 1'b0;
      cyc("sw_memwrite_wait", s_memwr(2'b01));
      bus.mem_ready = 1'b1;
      cyc("sw_memwrite_rdy", s_memwr(2'b01));

      // beq taken
      set_ins(7'b1100011, 3'b000, 1'b0);
      bus.zero = 1'b1;
      cyc("beq_t_fetch", s_fetch(1, 2'b10));
      cyc("beq_t_decode", s_dec(2'b10, 0));
      cyc("beq_t_beq",
          e(0, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0));

      // beq not taken
      bus.zero = 1'b0;
      cyc("beq_n_fetch", s_fetch(1, 2'b10));
      cyc("beq_n_decode", s_dec(2'b10, 0));
      cyc("beq_n_beq",
          e(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0));

      // jal
      set_ins(7'b1101111, 3'b000, 1'b0);
      bus.zero = 1'b1;
      cyc("jal_fetch", s_fetch(1, 2'b11));
      cyc("jal_decode", s_dec(2'b11, 0));
      cyc("jal_jal",
          e(0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0));
      cyc("jal_aluwb", s_aluwb(2'b11));

      // illegal opcode
      set_ins(7'b1111111, 3'b000, 1'b0);
      cyc("ill_fetch", s_fetch(1, 2'b00));
      cyc("ill_decode", s_dec(2'b00, 1));
      cyc("ill_back_fetch", s_fetch(1, 2'b00));
      cyc("ill_decode2", s_dec(2'b00, 1));

      // async reset during MEMWRITE
      set_ins(7'b0100011, 3'b000, 1'b0);
      cyc("rst_sw_fetch", s_fetch(1, 2'b01));
      cyc("rst_sw_decode", s_dec(2'b01, 0));
      cyc("rst_sw_memadr", s_memadr(2'b01));
      bus.mem_ready = 1'b0;
      #1;
      now("rst_sw_memwrite", s_memwr(2'b01));
      rst_n = 1'b0;
      #1;
      now("rst_async_drop", s_fetch(0, 2'b01) & ~18'h20000);
      @(posedge clk);
      #1;
      bus.mem_ready = 1'b1;
      rst_n = 1'b1;
      cyc("rst_after_fetch", s_fetch(1, 2'b01));
      cyc("rst_after_decode", s_dec(2'b01, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
